seg_display_converter: RTL and testbench

Sequential, parametrised binary-to-decimal display converter. Converts a WIDTH-bit unsigned value into DIGITS BCD digits using iterative shift-add-3 (double dabble), then drives one 7-segment pattern per digit. Flags values that do not fit in DIGITS digits. Sits between the distance or measurement datapath and the HEX display pins, and replaces fixed two-digit combinational conversion.

---
 rtl/seg_display_converter.sv | 132 +++++++++++++
 tb/tb_seg_display_converter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_converter.sv
// Binary to BCD (double dabble) with registered 7-segment outputs.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_converter #(
    parameter int WIDTH          = 7,
    parameter int DIGITS         = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [WIDTH-1:0]      BINARY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW,
    output logic [4*DIGITS-1:0]   BCD_OUT,
    output logic [7*DIGITS-1:0]   SEGMENTS
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam logic [6:0]    BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t          state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adjusted;
    logic [CW-1:0]   count;
    logic            ovf_flag;
    logic [SW-1:0]   seg_next;
    logic [3:0]      digit;
`ifdef LEADING_ZERO_BLANK_EN
    logic            lead;
`endif

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Walk from the top digit down so blanking stops at the first nonzero
    always_comb begin
        seg_next = '0;
        digit    = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lead     = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = scratch[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (digit != 4'd0)
                lead = 1'b0;
            if (lead && (i != 0) && !ovf_flag)
                seg_next[7*i +: 7] = BLANK;
            else
                seg_next[7*i +: 7] = encode(digit);
`else
            seg_next[7*i +: 7] = encode(digit);
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            OVERFLOW <= 1'b0;
            BCD_OUT  <= '0;
            SEGMENTS <= {DIGITS{BLANK}};
            shreg    <= '0;
            scratch  <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        shreg    <= BINARY;
                        scratch  <= '0;
                        ovf_flag <= 1'b0;
                        count    <= '0;
                        BUSY     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adjusted[BW-2:0], shreg[WIDTH-1]};
                    shreg   <= shreg << 1;
                    if (adjusted[BW-1])
                        ovf_flag <= 1'b1;
                    count <= count + CW'(1);
                    if (count == LAST)
                        state <= UPDATE;
                end
                UPDATE: begin
                    BCD_OUT  <= scratch;
                    OVERFLOW <= ovf_flag;
                    SEGMENTS <= seg_next;
                    DONE     <= 1'b1;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_display_converter.sv
// Randomised self-checking bench for seg_display_converter (defaults).
// Reference model uses decimal arithmetic and a display lookup table.
module tb_seg_display_converter;
    localparam int W = 7;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  binary = '0;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [4*D-1:0] bcd;
    logic [7*D-1:0] seg;

    int pass_cnt = 0;
    int total = 0;

    // active-low {g,f,e,d,c,b,a} for numerals 0..9
    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_display_converter dut (
        .CLK(clk), .RESET(reset), .START(start), .BINARY(binary),
        .BUSY(busy), .DONE(done), .OVERFLOW(ovf),
        .BCD_OUT(bcd), .SEGMENTS(seg)
    );

    always #5 clk = ~clk;

    function automatic void model(input int v, output logic [4*D-1:0] mb,
                                  output logic mo, output logic [7*D-1:0] ms);
        int p = 1;
        int rem;
        int msd = 0;
        int d [D];
        for (int i = 0; i < D; i++) p = p * 10;
        mo  = (v >= p);
        rem = v % p;
        for (int i = 0; i < D; i++) begin
            d[i] = rem % 10;
            rem  = rem / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < D; i++) begin
            mb[4*i +: 4] = 4'(d[i]);
            ms[7*i +: 7] = lut[d[i]];
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (!mo)
            for (int i = 1; i < D; i++)
                if (i > msd) ms[7*i +: 7] = 7'h7F;
`endif
    endfunction

    // Pulse START with v, return edges from acceptance to DONE (-1 on timeout)
    task automatic run_conv(input int v, output int lat, output logic bsy);
        @(negedge clk);
        start  = 1'b1;
        binary = W'(v);
        @(posedge clk);
        #1;
        bsy   = busy;
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int v, input int lat);
        logic [4*D-1:0] mb;
        logic mo;
        logic [7*D-1:0] ms;
        model(v, mb, mo, ms);
        total++;
        if (lat !== W + 1)
            $display("FAIL %s v=%0d latency got %0d want %0d", name, v, lat, W + 1);
        else pass_cnt++;
        total++;
        if (bcd !== mb)
            $display("FAIL %s v=%0d bcd got %h want %h", name, v, bcd, mb);
        else pass_cnt++;
        total++;
        if (ovf !== mo)
            $display("FAIL %s v=%0d ovf got %b want %b", name, v, ovf, mo);
        else pass_cnt++;
        total++;
        if (seg !== ms)
            $display("FAIL %s v=%0d seg got %h want %h", name, v, seg, ms);
        else pass_cnt++;
        total++;
        if (busy !== 1'b0)
            $display("FAIL %s v=%0d busy_in_done got %b want 0", name, v, busy);
        else pass_cnt++;
    endtask

    task automatic check_reset_vals(input string name);
        total++;
        if ({busy, done, ovf} !== 3'b000)
            $display("FAIL %s busy/done/ovf got %b want 000", name, {busy, done, ovf});
        else pass_cnt++;
        total++;
        if (bcd !== 8'h00)
            $display("FAIL %s bcd got %h want 00", name, bcd);
        else pass_cnt++;
        total++;
        if (seg !== 14'h3FFF)
            $display("FAIL %s seg got %h want 3fff", name, seg);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_normal();
        int lat;
        logic bsy;
        run_conv(42, lat, bsy);
        total++;
        if (bsy !== 1'b1)
            $display("FAIL normal busy_at_accept got %b want 1", bsy);
        else pass_cnt++;
        check_result("normal", 42, lat);
        total++;
        if (seg !== 14'b0011001_0100100)
            $display("FAIL normal seg42 got %b want 00110010100100", seg);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0)
            $display("FAIL normal done_pulse_width got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        int vals [5] = '{99, 100, 127, 5, 0};
        int lat;
        logic bsy;
        foreach (vals[i]) begin
            run_conv(vals[i], lat, bsy);
            check_result("boundary", vals[i], lat);
        end
    endtask

    task automatic test_random();
        int lat;
        int v;
        logic bsy;
        for (int n = 0; n < 24; n++) begin
            v = int'($urandom_range(0, (1 << W) - 1));
            run_conv(v, lat, bsy);
            check_result("random", v, lat);
        end
    endtask

    task automatic test_handshake();
        int v1;
        int lat = -1;
        int extra = 0;
        v1 = int'($urandom_range(0, 127));
        @(negedge clk);
        start  = 1'b1;
        binary = W'(v1);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n <= 5) binary = W'(v1 + 1 + n * 17);
            else start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check_result("handshake", v1, lat);
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0)
            $display("FAIL handshake queued_start got %0d active cycles want 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int v1, v2, lat;
        logic bsy;
        v1 = int'($urandom_range(0, 127));
        v2 = int'($urandom_range(0, 127));
        run_conv(v1, lat, bsy);
        check_result("b2b_first", v1, lat);
        start  = 1'b1;
        binary = W'(v2);
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if ({busy, done} !== 2'b10)
            $display("FAIL b2b accept busy/done got %b want 10", {busy, done});
        else pass_cnt++;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check_result("b2b_second", v2, lat);
    endtask

    task automatic test_abort();
        int lat;
        int seen = 0;
        logic bsy;
        @(negedge clk);
        start  = 1'b1;
        binary = W'(64);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        total++;
        if (seen !== 0)
            $display("FAIL abort done_pulses got %0d want 0", seen);
        else pass_cnt++;
        run_conv(64, lat, bsy);
        check_result("abort_rerun", 64, lat);
        total++;
        if (bcd !== 8'h64)
            $display("FAIL abort_rerun bcd64 got %h want 64", bcd);
        else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_normal();
        test_boundary();
        test_random();
        test_handshake();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
